// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared sizing helpers and shadow-entry layout for the hazard scoreboard unit.
package hazard_scoreboard_unit_pkg;

  localparam int unsigned FWD_NONE = 0;

  // Per-stage tag flags; rd and the EX source fields are sized by REG_AW in the users.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic is_load;
  } entry_flags_t;

  function automatic int unsigned sel_width(input int unsigned fwd_stages);
    return $clog2(fwd_stages + 1);
  endfunction

  // First shadow index at which a producer's result can be forwarded.
  function automatic int unsigned ready_index(input logic is_load, input int unsigned load_lat);
    return is_load ? 1 + load_lat : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage request and hazard/forwarding response bundle of the hazard scoreboard unit.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned SELW = hazard_scoreboard_unit_pkg::sel_width(FWD_STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              ex_branch_taken;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  logic [SELW-1:0]   fwd_a_sel;
  logic [SELW-1:0]   fwd_b_sel;
  logic [CNT_W-1:0]  perf_stall_cnt;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load,
           ex_branch_taken,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_is_load,
           ex_branch_taken,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
           perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// One EX operand's forwarding mux select: tag compare against the post-EX shadow stages.
module hazard_fwd_select
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic [REG_AW-1:0]                src,
  input  logic                             src_use,
  input  entry_flags_t [FWD_STAGES:1]      flags,
  input  logic [FWD_STAGES:1][REG_AW-1:0]  rd,
  output logic [sel_width(FWD_STAGES)-1:0] sel
);

  localparam int unsigned SELW = sel_width(FWD_STAGES);

  always_comb begin
    sel = SELW'(FWD_NONE);
    // Scan oldest to youngest so the youngest ready producer is the last to write sel.
    for (int unsigned k = FWD_STAGES; k >= 1; k--) begin
      if (src_use && (src != '0) && flags[k].valid && flags[k].regwrite && (rd[k] == src) &&
          (k >= ready_index(flags[k].is_load, LOAD_LAT))) begin
        sel = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline: shadow tag pipeline from EX to WB,
// load-use stall, branch flush, operand forwarding selects and saturating perf counters.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 32
) (
  input logic                     clk,
  input logic                     rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int unsigned SELW = sel_width(FWD_STAGES);

  entry_flags_t [FWD_STAGES:0]     flags_q, flags_d;
  logic [FWD_STAGES:0][REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0]               ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0]               ex_rs2_q, ex_rs2_d;
  logic                            ex_use_rs1_q, ex_use_rs1_d;
  logic                            ex_use_rs2_q, ex_use_rs2_d;
  logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]                flush_cnt_q, flush_cnt_d;

  logic            load_use;
  logic            stall;
  logic            flush;
  logic            capture;
  logic [SELW-1:0] fwd_a_sel;
  logic [SELW-1:0] fwd_b_sel;

  always_comb begin
    load_use = 1'b0;
    for (int unsigned s = 0; s <= FWD_STAGES; s++) begin
      if (hz.id_valid && flags_q[s].valid && flags_q[s].regwrite && (rd_q[s] != '0) &&
          (s + 1 < ready_index(flags_q[s].is_load, LOAD_LAT)) &&
          ((hz.id_use_rs1 && (rd_q[s] == hz.id_rs1)) ||
           (hz.id_use_rs2 && (rd_q[s] == hz.id_rs2)))) begin
        load_use = 1'b1;
      end
    end
    // A taken branch squashes the stalled instruction anyway, so flush wins.
    flush   = hz.ex_branch_taken;
    stall   = load_use && !flush;
    capture = hz.id_valid && !stall && !flush;
  end

  always_comb begin
    flags_d      = '0;
    rd_d         = '0;
    ex_rs1_d     = '0;
    ex_rs2_d     = '0;
    ex_use_rs1_d = 1'b0;
    ex_use_rs2_d = 1'b0;
    for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
      flags_d[k] = flags_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
    if (capture) begin
      flags_d[0].valid    = 1'b1;
      flags_d[0].regwrite = hz.id_regwrite;
      flags_d[0].is_load  = hz.id_is_load;
      rd_d[0]             = hz.id_rd;
      ex_rs1_d            = hz.id_rs1;
      ex_rs2_d            = hz.id_rs2;
      ex_use_rs1_d        = hz.id_use_rs1;
      ex_use_rs2_d        = hz.id_use_rs2;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q      <= '0;
      rd_q         <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_use_rs1_q <= 1'b0;
      ex_use_rs2_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      flags_q      <= flags_d;
      rd_q         <= rd_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_use_rs1_q <= ex_use_rs1_d;
      ex_use_rs2_q <= ex_use_rs2_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  hazard_fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT  (LOAD_LAT)
  ) u_fwd_a (
    .src    (ex_rs1_q),
    .src_use(ex_use_rs1_q),
    .flags  (flags_q[FWD_STAGES:1]),
    .rd     (rd_q[FWD_STAGES:1]),
    .sel    (fwd_a_sel)
  );

  hazard_fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT  (LOAD_LAT)
  ) u_fwd_b (
    .src    (ex_rs2_q),
    .src_use(ex_use_rs2_q),
    .flags  (flags_q[FWD_STAGES:1]),
    .rd     (rd_q[FWD_STAGES:1]),
    .sel    (fwd_b_sel)
  );

  assign hz.stall_if       = stall;
  assign hz.stall_id       = stall;
  assign hz.flush_id       = flush;
  assign hz.flush_ex       = flush || stall;
  assign hz.fwd_a_sel      = fwd_a_sel;
  assign hz.fwd_b_sel      = fwd_b_sel;
  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: default build (A) and LOAD_LAT=2/FWD_STAGES=3/CNT_W=3 build (B).
module tb_hazard_scoreboard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic       st;
    logic       fid;
    logic       fex;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct packed {
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } obs_t;

  localparam stim_t NOP   = '0;
  localparam exp_t  Z     = '0;
  localparam exp_t  STALL = 7'b1_0_1_00_00;
  localparam exp_t  FLUSH = 7'b0_1_1_00_00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_AW(5), .FWD_STAGES(2), .CNT_W(32)) if_a ();
  hazard_scoreboard_unit_if #(.REG_AW(5), .FWD_STAGES(3), .CNT_W(3))  if_b ();

  hazard_scoreboard_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .hz(if_a)
  );
  hazard_scoreboard_unit #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .hz(if_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  obs_t        exp_q[$];
  logic [31:0] sc_a = '0, fc_a = '0;
  logic [2:0]  sc_b = '0, fc_b = '0;

  function automatic stim_t ins(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic rw, input logic ld);
    stim_t s;
    s.v = v; s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
    s.rd = 5'(rd); s.rw = rw; s.ld = ld; s.br = 1'b0;
    return s;
  endfunction

  function automatic stim_t alu(input int rd, input int rs1, input int rs2);
    return ins(1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  function automatic stim_t addi(input int rd, input int rs1);
    return ins(1'b1, rs1, 1'b1, 0, 1'b0, rd, 1'b1, 1'b0);
  endfunction

  function automatic stim_t ld(input int rd, input int rs1);
    return ins(1'b1, rs1, 1'b1, 0, 1'b0, rd, 1'b1, 1'b1);
  endfunction

  function automatic stim_t with_br(input stim_t s);
    stim_t r;
    r = s; r.br = 1'b1;
    return r;
  endfunction

  function automatic exp_t fwd(input int fa, input int fb);
    exp_t e;
    e = '0; e.fa = 2'(fa); e.fb = 2'(fb);
    return e;
  endfunction

  function automatic obs_t obs_a();
    return {if_a.stall_if, if_a.stall_id, if_a.flush_id, if_a.flush_ex, if_a.fwd_a_sel,
            if_a.fwd_b_sel, if_a.perf_stall_cnt, if_a.perf_flush_cnt};
  endfunction

  function automatic obs_t obs_b();
    return {if_b.stall_if, if_b.stall_id, if_b.flush_id, if_b.flush_ex, if_b.fwd_a_sel,
            if_b.fwd_b_sel, 29'd0, if_b.perf_stall_cnt, 29'd0, if_b.perf_flush_cnt};
  endfunction

  task automatic apply_a(input stim_t s);
    if_a.id_valid = s.v;   if_a.id_rs1 = s.rs1; if_a.id_use_rs1 = s.u1;
    if_a.id_rs2 = s.rs2;   if_a.id_use_rs2 = s.u2; if_a.id_rd = s.rd;
    if_a.id_regwrite = s.rw; if_a.id_is_load = s.ld; if_a.ex_branch_taken = s.br;
  endtask

  task automatic apply_b(input stim_t s);
    if_b.id_valid = s.v;   if_b.id_rs1 = s.rs1; if_b.id_use_rs1 = s.u1;
    if_b.id_rs2 = s.rs2;   if_b.id_use_rs2 = s.u2; if_b.id_rd = s.rd;
    if_b.id_regwrite = s.rw; if_b.id_is_load = s.ld; if_b.ex_branch_taken = s.br;
  endtask

  // Drive one cycle and queue the outputs expected before the next edge; counters advance after.
  task automatic drive_cycle_a(input stim_t s, input exp_t e);
    obs_t w;
    apply_a(s);
    w = {e.st, e.st, e.fid, e.fex, e.fa, e.fb, sc_a, fc_a};
    exp_q.push_back(w);
    if (e.st && sc_a != 32'hFFFF_FFFF) sc_a = sc_a + 1;
    if (e.fid && fc_a != 32'hFFFF_FFFF) fc_a = fc_a + 1;
  endtask

  task automatic drive_cycle_b(input stim_t s, input exp_t e);
    obs_t w;
    apply_b(s);
    w = {e.st, e.st, e.fid, e.fex, e.fa, e.fb, 29'd0, sc_b, 29'd0, fc_b};
    exp_q.push_back(w);
    if (e.st && sc_b != 3'd7) sc_b = sc_b + 1;
    if (e.fid && fc_b != 3'd7) fc_b = fc_b + 1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    rst = 1'b0;
    apply_a(ld(5, 2));
    apply_b(ld(3, 2));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    exp_q.push_back('0);
    exp_q.push_back('0);
    got = obs_a(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_a got %p want %p", got, want); end
    got = obs_b(); want = exp_q.pop_front(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL reset_b got %p want %p", got, want); end
    rst = 1'b1;
    apply_a(NOP);
    apply_b(NOP);
  endtask

  task automatic test_load_use();
    stim_t s [6];
    exp_t  e [6];
    obs_t  got, want;
    s = '{ld(5, 2), alu(6, 5, 1), alu(6, 5, 1), NOP, NOP, NOP};
    e = '{Z, STALL, Z, fwd(2, 0), Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL load_use[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_alu_fwd();
    stim_t s [5];
    exp_t  e [5];
    obs_t  got, want;
    s = '{alu(7, 1, 2), alu(8, 7, 7), NOP, NOP, NOP};
    e = '{Z, Z, fwd(1, 1), Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL alu_fwd[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_youngest();
    stim_t s [6];
    exp_t  e [6];
    obs_t  got, want;
    s = '{addi(7, 1), addi(7, 1), alu(9, 7, 0), NOP, NOP, NOP};
    e = '{Z, Z, Z, fwd(1, 0), Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL youngest[%0d] got %p want %p", i, got, want); end
    end
  endtask

  // x0 producers and sources with a clear use bit must never stall or forward.
  task automatic test_no_hazard();
    stim_t s [9];
    exp_t  e [9];
    obs_t  got, want;
    s = '{alu(0, 1, 2), alu(11, 0, 0), ld(0, 2), ins(1'b1, 0, 1'b1, 0, 1'b1, 12, 1'b1, 1'b0),
          ld(5, 2), ins(1'b1, 1, 1'b1, 5, 1'b0, 10, 1'b1, 1'b0), NOP, NOP, NOP};
    e = '{Z, Z, Z, Z, Z, Z, Z, Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL no_hazard[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s [8];
    exp_t  e [8];
    obs_t  got, want;
    s = '{ld(5, 2), ld(6, 5), ld(6, 5), alu(7, 6, 5), alu(7, 6, 5), NOP, NOP, NOP};
    e = '{Z, STALL, Z, 7'b1_0_1_10_00, Z, fwd(2, 0), Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL back_to_back[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_flush_beats_stall();
    stim_t s [5];
    exp_t  e [5];
    obs_t  got, want;
    s = '{ld(5, 2), with_br(alu(6, 5, 1)), NOP, NOP, NOP};
    e = '{Z, FLUSH, Z, Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL flush_stall[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s [5];
    exp_t  e [5];
    obs_t  got, want;
    s = '{ld(5, 2), alu(6, 5, 1), alu(6, 5, 1), NOP, NOP};
    e = '{Z, STALL, Z, Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      if (i == 2) begin
        rst = 1'b1;
        sc_a = '0; fc_a = '0; sc_b = '0; fc_b = '0;
      end
      drive_cycle_a(s[i], e[i]);
      #2;
      got = obs_a(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL reset_mid[%0d] got %p want %p", i, got, want); end
      if (i == 1) rst = 1'b0;
    end
  endtask

  task automatic test_load_lat2();
    stim_t s [8];
    exp_t  e [8];
    obs_t  got, want;
    s = '{ld(3, 2), alu(4, 3, 1), alu(4, 3, 1), alu(4, 3, 1), NOP, NOP, NOP, NOP};
    e = '{Z, STALL, STALL, Z, fwd(3, 0), Z, Z, Z};
    foreach (s[i]) begin
      @(negedge clk);
      drive_cycle_b(s[i], e[i]);
      #2;
      got = obs_b(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL load_lat2[%0d] got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_counter_saturation();
    stim_t st;
    obs_t  got, want;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      st = NOP;
      st.br = (i < 10);
      drive_cycle_b(st, (i < 10) ? FLUSH : Z);
      #2;
      got = obs_b(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL flush_sat[%0d] got %p want %p", i, got, want); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    apply_a(NOP);
    apply_b(NOP);
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_youngest();
    test_no_hazard();
    test_back_to_back();
    test_flush_beats_stall();
    test_reset_mid_stall();
    test_load_lat2();
    test_counter_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
